// File: rtl/execute_bru_resolve.sv
// Branch resolution stage: registers the BRU result, detects mispredicts,
// holds a one-deep redirect toward fetch and counts mispredicts (saturating).
module execute_bru_resolve #(
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_target,
  input  logic [31:0]      i_wavefront,
  input  logic             i_taken,
  input  logic             i_pred_taken,
  input  logic [31:0]      i_pred_target,
  input  logic             i_link_en,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_redirect_valid,
  input  logic             i_redirect_ready,
  output logic [31:0]      o_redirect_pc,
  output logic             o_wb_valid,
  output logic [TAG_W-1:0] o_wb_tag,
  output logic             o_wb_link,
  output logic [31:0]      o_wb_value,
  output logic             o_wb_excp,
  output logic [CNT_W-1:0] o_mispredict_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t             state_p1, state_nxt;
  logic               vld_p1;
  logic [TAG_W-1:0]   tag_p1;
  logic               link_p1;
  logic [31:0]        value_p1;
  logic               excp_p1;
  logic [31:0]        redirect_pc_p1;
  logic [CNT_W-1:0]   cnt_p1;

  logic               accept;
  logic               excp;
  logic               mispredict;
  logic [31:0]        actual;
  logic               pc_unused;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + 1'b1;
  endfunction

  // The branch PC is carried for debug visibility only; the link value
  // arrives precomputed from the AGU.
  assign pc_unused = ^i_pc;

  assign o_ready    = (state_p1 == IDLE) | i_redirect_ready;
  assign accept     = i_valid & o_ready & ~i_flush;
  assign actual     = i_taken ? i_target : i_wavefront;
  assign excp       = i_taken & (i_target[1:0] != 2'b00);
  // A faulting branch never redirects; not-taken vs not-taken ignores target.
  assign mispredict = ~excp & ((i_taken != i_pred_taken) |
                               (i_taken & (i_target != i_pred_target)));

  // Next-state: flush wins, a new mispredict (re)arms, a handshake releases.
  always_comb begin
    state_nxt = state_p1;
    if (i_flush)
      state_nxt = IDLE;
    else if (accept && mispredict)
      state_nxt = PENDING;
    else if (state_p1 == PENDING && i_redirect_ready)
      state_nxt = IDLE;
  end

  // ---- stage p0 -> p1 boundary: register completion, redirect and counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_p1       <= IDLE;
      vld_p1         <= 1'b0;
      tag_p1         <= '0;
      link_p1        <= 1'b0;
      value_p1       <= '0;
      excp_p1        <= 1'b0;
      redirect_pc_p1 <= '0;
      cnt_p1         <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (accept) begin
        vld_p1   <= 1'b1;
        tag_p1   <= i_tag;
        link_p1  <= i_link_en & ~excp;
        value_p1 <= i_wavefront;
        excp_p1  <= excp;
        if (mispredict) begin
          redirect_pc_p1 <= actual;
          cnt_p1         <= sat_inc(cnt_p1);
        end
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign o_redirect_valid = (state_p1 == PENDING);
  assign o_redirect_pc    = redirect_pc_p1;
  assign o_wb_valid       = vld_p1;
  assign o_wb_tag         = tag_p1;
  assign o_wb_link        = link_p1;
  assign o_wb_value       = value_p1;
  assign o_wb_excp        = excp_p1;
  assign o_mispredict_cnt = cnt_p1;

endmodule

// File: doc/execute_bru_resolve.md
# execute_bru_resolve

Branch resolution stage directly downstream of the BRU address-generation unit. It captures the computed target and link/fall-through address (PC+8) together with the condition outcome, and compares the actual next PC against the front-end prediction. It issues a held redirect request to fetch on a mispredict, a single-cycle link writeback toward the ROB/PRF, and a misaligned-target exception flag. It is a single registered stage with a one-deep redirect hold and a saturating mispredict counter.

## Interface
- TAG_W, 6, width of ROB destination tag
- CNT_W, 16, width of saturating mispredict counter
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- i_flush  in  1  pipeline flush; kills pending/incoming work
- i_valid  in  1  upstream branch result valid
- o_ready  out  1  stage can accept; = (state==IDLE) | i_redirect_ready
- i_pc  in  32  branch instruction PC
- i_target  in  32  AGU target
- i_wavefront  in  32  AGU PC+8 (link value / not-taken next PC)
- i_taken  in  1  resolved condition (1 for jumps)
- i_pred_taken  in  1  front-end predicted direction
- i_pred_target  in  32  front-end predicted target
- i_link_en  in  1  instruction writes link register
- i_tag  in  TAG_W  ROB tag
- o_redirect_valid  out  1  redirect request to fetch
- i_redirect_ready  in  1  fetch accepts redirect
- o_redirect_pc  out  32  corrected next PC
- o_wb_valid  out  1  completion pulse (every accepted branch)
- o_wb_tag  out  TAG_W  completing ROB tag
- o_wb_link  out  1  o_wb_value must be written to PRF
- o_wb_value  out  32  link value (registered i_wavefront)
- o_wb_excp  out  1  taken target misaligned (target[1:0]!=0)
- o_mispredict_cnt  out  CNT_W  saturating mispredict count

## Operation
- Accept = i_valid & o_ready & ~i_flush.
- actual = i_taken ? i_target : i_wavefront.
- excp = i_taken & (i_target[1:0] != 2'b00).
- mispredict = ~excp & ((i_taken != i_pred_taken) | (i_taken & (i_target != i_pred_target))). Predicted not-taken with not-taken outcome never mispredicts, regardless of i_pred_target.
- On accept: o_wb_valid<=1, o_wb_tag<=i_tag, o_wb_link<=i_link_en & ~excp, o_wb_value<=i_wavefront, o_wb_excp<=excp; if mispredict: o_redirect_pc<=actual, state->PENDING, counter +1 unless all-ones.
- No accept: o_wb_valid<=0 (writeback is a one-cycle pulse, never back-pressured).
- FSM: IDLE -> PENDING on accept with mispredict. PENDING -> IDLE when i_redirect_ready & no new mispredict accept; PENDING stays PENDING (new redirect_pc loaded) when i_redirect_ready and same-cycle accept mispredicts. PENDING with ~i_redirect_ready: hold o_redirect_pc stable, o_ready=0.
- o_redirect_valid = (state==PENDING).
- Priority: ~resetn > i_flush > accept/handshake.
- i_flush: state->IDLE, o_wb_valid<=0, incoming beat dropped; counter unchanged. A redirect handshake completing in the flush cycle counts as delivered.
- Reset: state IDLE, o_redirect_valid=0, o_redirect_pc=0, o_wb_valid=0, o_wb_tag=0, o_wb_link=0, o_wb_value=0, o_wb_excp=0, o_mispredict_cnt=0.
- Counter wraps never: at 2^CNT_W-1 holds.

## Timing
- Latency: input accepted at edge N -> o_wb_* and o_redirect_valid visible after edge N (cycle N+1).
- o_ready combinational only from state and i_redirect_ready; no path from i_valid.
- Redirect handshake completes at edge where o_redirect_valid & i_redirect_ready; back-to-back mispredicts sustain one redirect per cycle while fetch is ready.
- While PENDING and stalled, upstream sees o_ready=0; o_wb_valid stays 0 (no duplicate completion).
- Reset asserted mid-PENDING: redirect dropped at that edge; outputs at reset values next cycle.

## Test plan
- Correct prediction: i_pc=0x1000, taken, target=0x2000, pred_taken=1, pred_target=0x2000, link_en=1 -> next cycle o_wb_valid=1, o_wb_value=0x1008, o_wb_link=1, o_redirect_valid=0, counter 0.
- Direction mispredict: pred_taken=1, taken=0, wavefront=0x1008 -> o_redirect_valid=1, o_redirect_pc=0x1008, counter=1; hold 3 cycles with i_redirect_ready=0, o_ready=0, pc stable; ready=1 -> IDLE next cycle.
- Target mispredict back-to-back: two beats both mispredict, i_redirect_ready=1 -> redirects 0x3000 then 0x4000 on consecutive cycles, o_ready=1 throughout, counter=2.
- Misaligned: taken, target=0x2002 -> o_wb_excp=1, o_wb_link=0, no redirect, counter unchanged.
- Flush during PENDING with ready=0 plus i_valid=1 -> next cycle o_redirect_valid=0, o_wb_valid=0, state IDLE.
- Saturation: CNT_W=2, five mispredicts -> o_mispredict_cnt=3; resetn=0 one cycle -> all outputs 0.
